// File: rtl/regwrite_arbiter_pkg.sv
// Shared widths and types for the register-file write front end.
// Holds the write-entry layout shared by the FIFO and the arbiter.
package regwrite_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_entry_t;

    // r0 is hardwired to zero, so an entry aimed at it never raises the write enable.
    function automatic logic writes_reg(input reg_addr_t addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/regwrite_arbiter_lu_fifo.sv
// In-order FIFO for long-latency results, with per-entry destination compare
// so hazard logic can see which registers are still waiting to be written.
module regwrite_arbiter_lu_fifo
    import regwrite_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wr_entry_t                push_entry,
    input  logic                     pop,
    output wr_entry_t                head_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    input  reg_addr_t                query_addr,
    output logic [DEPTH-1:0]         entry_hit
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    wr_entry_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level      = wr_ptr_q - rd_ptr_q;
    assign full       = (level == LEVEL_FULL);
    assign empty      = (level == '0);
    assign head_entry = mem_q[rd_ptr_q[AW-1:0]];

    // A slot is live when its distance from the read pointer is below the level.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [AW-1:0] offset;
        assign offset        = AW'(gi) - rd_ptr_q[AW-1:0];
        assign entry_hit[gi] = ({1'b0, offset} < level) && (mem_q[gi].addr == query_addr);
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the single
// register-file write port; flags pending destinations and starvation stalls.
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_valid,
    input  logic [REG_ADDR_W-1:0]    pipe_addr,
    input  logic [REG_DATA_W-1:0]    pipe_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [REG_ADDR_W-1:0]    lu_addr,
    input  logic [REG_DATA_W-1:0]    lu_data,
    input  logic [REG_ADDR_W-1:0]    query_addr,
    output logic                     pend_hit,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     stall_req,
    output logic                     write_reg,
    output logic [REG_ADDR_W-1:0]    dstreg_addr,
    output logic [REG_DATA_W-1:0]    dstreg_data
);

    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    wr_entry_t        fifo_head;
    logic [DEPTH-1:0] entry_hit;

    logic      lu_accept;
    logic      bypass;
    logic      sel_valid;
    wr_entry_t sel_entry;

    logic            write_reg_q;
    logic            write_reg_d;
    reg_addr_t       dstreg_addr_q;
    reg_addr_t       dstreg_addr_d;
    reg_data_t       dstreg_data_q;
    reg_data_t       dstreg_data_d;
    logic [CW-1:0]   starve_cnt_q;
    logic [CW-1:0]   starve_cnt_d;
    logic            stall_req_q;
    logic            stall_req_d;

    regwrite_arbiter_lu_fifo #(
        .DEPTH (DEPTH)
    ) u_lu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry ('{addr: lu_addr, data: lu_data}),
        .pop        (fifo_pop),
        .head_entry (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level),
        .query_addr (query_addr),
        .entry_hit  (entry_hit)
    );

    always_comb begin
        // Readiness follows registered occupancy only; no pop-through when full.
        lu_ready  = !fifo_full && !rst;
        lu_accept = lu_valid && lu_ready;
        fifo_pop  = !pipe_valid && !fifo_empty;
        bypass    = !pipe_valid && fifo_empty && lu_accept;
        fifo_push = lu_accept && !bypass;

        sel_valid = 1'b0;
        sel_entry = '{addr: dstreg_addr_q, data: dstreg_data_q};
        if (pipe_valid) begin
            sel_valid = 1'b1;
            sel_entry = '{addr: pipe_addr, data: pipe_data};
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_entry = fifo_head;
        end else if (lu_accept) begin
            sel_valid = 1'b1;
            sel_entry = '{addr: lu_addr, data: lu_data};
        end

        write_reg_d   = sel_valid && writes_reg(sel_entry.addr);
        dstreg_addr_d = sel_entry.addr;
        dstreg_data_d = sel_entry.data;

        starve_cnt_d = '0;
        if (!fifo_empty && !fifo_pop) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + CNT_ONE;
        end

        // Once raised, only a pop drops the stall request, even if the pipe keeps winning.
        stall_req_d = stall_req_q;
        if (fifo_pop) begin
            stall_req_d = 1'b0;
        end else if (starve_cnt_d == STARVE_MAX) begin
            stall_req_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg_q   <= 1'b0;
            dstreg_addr_q <= '0;
            dstreg_data_q <= '0;
            starve_cnt_q  <= '0;
            stall_req_q   <= 1'b0;
        end else begin
            write_reg_q   <= write_reg_d;
            dstreg_addr_q <= dstreg_addr_d;
            dstreg_data_q <= dstreg_data_d;
            starve_cnt_q  <= starve_cnt_d;
            stall_req_q   <= stall_req_d;
        end
    end

    assign pend_hit    = (query_addr != ZERO_REG) && (|entry_hit);
    assign stall_req   = stall_req_q;
    assign write_reg   = write_reg_q;
    assign dstreg_addr = dstreg_addr_q;
    assign dstreg_data = dstreg_data_q;

endmodule

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Write-side front end for the 32×32 register file. It merges two result sources onto the register file's single write port (`write_reg` / `dstreg_addr` / `dstreg_data`):

- the in-order pipeline writeback, which is always accepted;
- a long-latency unit (multiplier/divider/load miss), which uses a valid/ready handshake and is buffered in a small FIFO.

It also reports pending destinations to hazard logic and requests a pipeline bubble when buffered results starve.

## Interface

Parameters:
- `DEPTH`, 2 — long-latency FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4 — consecutive non-popped cycles with FIFO non-empty before `stall_req` asserts.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `pipe_valid` in 1 — pipeline writeback present this cycle.
- `pipe_addr` in 5 — pipeline destination register.
- `pipe_data` in 32 — pipeline result.
- `lu_valid` in 1 — long-latency result offered.
- `lu_ready` out 1 — long-latency result accepted when high with `lu_valid`.
- `lu_addr` in 5 — long-latency destination.
- `lu_data` in 32 — long-latency result.
- `query_addr` in 5 — source register probed by hazard logic.
- `pend_hit` out 1 — `query_addr` (≠0) matches a valid FIFO entry. Combinational.
- `fifo_level` out clog2(DEPTH)+1 — current FIFO occupancy.
- `stall_req` out 1 — registered request for a pipeline bubble.
- `write_reg` out 1 — register file write enable. Registered.
- `dstreg_addr` out 5 — register file write address. Registered.
- `dstreg_data` out 32 — register file write data. Registered.

## Operation

**Per-cycle selection (one write per cycle), in priority order:**
1. `pipe_valid`: emit the pipe entry.
2. FIFO non-empty: pop the head and emit it.
3. Accepted `lu` beat with FIFO empty: bypass directly to the output. It is not enqueued.
4. Otherwise: `write_reg`=0.

**Enqueue:**
- An accepted `lu` beat is enqueued unless it takes the bypass path.
- Push and pop may occur in the same cycle; `fifo_level` stays unchanged.
- `lu_ready` = !full, based on registered occupancy only. There is no same-cycle pop-through when full.

**Register r0:**
- Any selected entry with addr 0 is consumed (popped/accepted) but emits `write_reg`=0.
- `dstreg_addr` and `dstreg_data` still update.

**Ordering:**
- The FIFO is strictly in order.
- Hazard logic must not issue a pipe write to an address for which `pend_hit` is high; the block does not check this.
- `pend_hit` covers FIFO entries only. An entry already in the output register is covered by the register file's same-cycle write forwarding.

**Starvation counter** (width clog2(STARVE_LIMIT)+1):
- Increments each cycle the FIFO is non-empty and not popped.
- Clears on any pop, or when the FIFO is empty.
- `stall_req` is set when the counter reaches `STARVE_LIMIT`, and cleared on the cycle after the next pop.
- Upstream guarantees `pipe_valid`=0 in the cycle after `stall_req` rises.
- If violated, the pipe still wins and no data is lost; `stall_req` stays high.

**Reset (synchronous):**
- Clears the FIFO pointers, counter, `stall_req`, `write_reg`, `dstreg_addr`, and `dstreg_data` (all 0).
- Discards in-flight FIFO contents.
- `lu_ready` = 1 and `fifo_level` = 0 the cycle after reset deasserts.
- A `lu` beat offered during reset is not accepted (`lu_ready` forced 0 while `rst`=1).

## Timing

- Latency from input to `write_reg`/`dstreg_*`: 1 cycle. The value presented in cycle N is written at the edge ending cycle N+1.
- Bypass latency: 1 cycle. FIFO path: ≥2 cycles.
- `lu_ready`, `fifo_level`, and `stall_req` derive from registered state. `pend_hit` is combinational from `query_addr` and FIFO state.
- Simultaneous pipe + `lu` with FIFO empty: the pipe is emitted and `lu` is enqueued (level 1).
- FIFO full + `lu_valid`: `lu_ready`=0; `lu` holds its beat until accepted.

## Structure

- Shared package/define file: register address width (5), data width (32), zero-register index.
- One natural sub-module: `lu_fifo`, a parameterised synchronous FIFO with push/pop/full/empty/level and per-entry address compare outputs for `pend_hit`.
- Arbitration, bypass, starvation counter, and output registers live in the top module.

## Test plan

- **Bypass:** reset, then `lu_valid`=1, addr 5, data 0xDEADBEEF, pipe idle → next cycle `write_reg`=1, `dstreg_addr`=5, `dstreg_data`=0xDEADBEEF; `fifo_level` stays 0.
- **Priority and ordering:** pipe (3, 0x11) and `lu` (7, 0x22) in the same cycle, then idle → outputs (3, 0x11) then (7, 0x22) on consecutive cycles; `pend_hit` for `query_addr`=7 is high for exactly one cycle.
- **Full backpressure:** `pipe_valid` held high with `lu` offering 3 beats (DEPTH=2) → `lu_ready` drops after 2 accepts; the third beat is held; after the pipe idles, outputs drain in order with no loss.
- **Starvation:** FIFO holds 1 entry, `pipe_valid` held high → `stall_req` rises after 4 cycles; one pipe-idle cycle pops the entry; `stall_req` clears the following cycle.
- **r0 drop:** `lu` addr 0, data 0x55 → `write_reg` stays 0, the beat is consumed, and `fifo_level` returns to 0.
- **Mid-operation reset:** FIFO at 2 with `stall_req`=1, then assert `rst` for one cycle → all outputs 0, `lu_ready`=1, and no stale writes appear afterward.
